// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path: channel state
// encoding, button count and counter sizing helper.
package btn_pkg;

    // Number of physical push-buttons handled by the conditioner.
    localparam int unsigned NUM_BTN = 4;

    // Per-button channel state. IDLE is the reset state.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_DB_RELEASE = 3'd4
    } chan_state_t;

    // Width of the shared down-counter. The counter is only ever loaded with
    // (parameter - 1), so $clog2 of the largest parameter is sufficient.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Counter width for the default timing (20 ms / 500 ms / 100 ms at 100 MHz).
    localparam int unsigned DEFAULT_CNT_W = cnt_width(2_000_000, 50_000_000, 10_000_000);

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw switch inputs and the conditioned consumers.
// There is no handshake: btn_raw is free-running and asynchronous; btn_press
// and btn_release are single-cycle strobes in clk, valid in every cycle they
// are high and never back-pressured; btn_level is a steady debounced level.
interface btn_conditioner_if;
    import btn_pkg::*;

    logic        [NUM_BTN-1:0] btn_raw;
    logic        [NUM_BTN-1:0] btn_level;
    logic        [NUM_BTN-1:0] btn_press;
    logic        [NUM_BTN-1:0] btn_release;
    chan_state_t [NUM_BTN-1:0] dbg_state;

    // The switch side: drives raw buttons, observes the conditioned result.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  dbg_state
    );

    // The conditioner: consumes raw buttons, produces clean strobes.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output dbg_state
    );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce / hold-to-repeat FSM with a
// single saturating down-counter, and registered level / press / release.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES         = 2_000_000,
    parameter int unsigned RPT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned RPT_PERIOD_CYCLES = 10_000_000,
    parameter bit          REPEAT_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_i,
    output logic        level_o,
    output logic        press_o,
    output logic        release_o,
    output chan_state_t state_o
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES, RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES);

    // Each window is counted down to zero, so the load value is one less
    // than the window length: the expiry cycle is the last cycle of it.
    localparam logic [CNT_W-1:0] DB_LOAD     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(RPT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(RPT_PERIOD_CYCLES - 1);

    logic             sync1_q, sync2_q;
    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_dec;

    // Saturating decrement: an expired counter stays at zero, so a button
    // held in HELD with repeat disabled never wraps.
    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    // Next-state, counter and output decode for the channel FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_dec;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = DB_LOAD;
                end
            end

            ST_DB_PRESS: begin
                if (!sync2_q) begin
                    // Bounce: drop back and restart the window on the next 1.
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_HELD;
                    cnt_d   = DELAY_LOAD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end
            end

            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = DB_LOAD;
                end else if (REPEAT_EN && (cnt_q == '0)) begin
                    state_d = ST_REPEAT;
                    cnt_d   = PERIOD_LOAD;
                    press_d = 1'b1;
                end
            end

            ST_REPEAT: begin
                if (!sync2_q) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = DB_LOAD;
                end else if (cnt_q == '0) begin
                    cnt_d   = PERIOD_LOAD;
                    press_d = 1'b1;
                end
            end

            ST_DB_RELEASE: begin
                if (sync2_q) begin
                    // Release was a bounce: the button is still held, so the
                    // repeat delay restarts without a fresh press pulse.
                    state_d = ST_HELD;
                    cnt_d   = DELAY_LOAD;
                end else if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign state_o   = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// Four independent button channels. btn_press replaces the raw btn bus into
// the time, alarm and date setters; btn_level is available for mode logic.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES         = 2_000_000,
    parameter int unsigned RPT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned RPT_PERIOD_CYCLES = 10_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_EN  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst_n,
    btn_conditioner_if.slave   bus
);

    logic        [NUM_BTN-1:0] level_w;
    logic        [NUM_BTN-1:0] press_w;
    logic        [NUM_BTN-1:0] release_w;
    chan_state_t [NUM_BTN-1:0] state_w;

    // Channels never interact; each only sees its own raw input.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DB_CYCLES         (DB_CYCLES),
            .RPT_DELAY_CYCLES  (RPT_DELAY_CYCLES),
            .RPT_PERIOD_CYCLES (RPT_PERIOD_CYCLES),
            .REPEAT_EN         (REPEAT_EN[i])
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_i     (bus.btn_raw[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i]),
            .state_o   (state_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.dbg_state   = state_w;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side conditioning block for the digital clock. It takes the four raw push-buttons and produces clean single-cycle pulses, so the time-set, alarm-set and date-set logic never sees switch bounce. Each button is synchronized, debounced, edge-detected and given optional hold-to-repeat. Its outputs replace the raw `btn[3:0]` bus that feeds the clock, alarm and date blocks.

## Interface
- `DB_CYCLES`, default 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz); must be ≥2.
- `RPT_DELAY_CYCLES`, default 50_000_000: held cycles before the first auto-repeat pulse; must be ≥2.
- `RPT_PERIOD_CYCLES`, default 10_000_000: cycles between subsequent repeat pulses; must be ≥2.
- `REPEAT_EN`, default 4'b1111: per-button auto-repeat enable.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  unsynchronized button inputs, active-high.
- `btn_level`  out  4  debounced level.
- `btn_press`  out  4  one-cycle pulse on accepted press and on each repeat.
- `btn_release`  out  4  one-cycle pulse on accepted release.

## Operation
- Per button: a 2-FF synchronizer (reset to 0) feeds an independent channel FSM with one down-counter sized for the largest parameter.
- Channel states:
  - IDLE: waits for a synced 1, then moves to DB_PRESS with the counter loaded.
  - DB_PRESS: a synced 0 returns to IDLE.
    - After DB_CYCLES consecutive synced-1 cycles, moves to HELD.
    - Raises `btn_press` and sets `btn_level`.
  - HELD: counter loaded with RPT_DELAY_CYCLES.
    - If REPEAT_EN[i] is set and the count expires with the input still 1, moves to REPEAT and pulses `btn_press`.
    - A synced 0 moves to DB_RELEASE.
  - REPEAT: pulses `btn_press` every RPT_PERIOD_CYCLES while the input stays 1.
    - A synced 0 moves to DB_RELEASE.
  - DB_RELEASE: a synced 1 returns to HELD with the repeat counter restarted; no extra press pulse.
    - After DB_CYCLES consecutive synced-0 cycles, moves to IDLE.
    - Clears `btn_level` and pulses `btn_release`.
- All outputs are registered. Pulses are exactly one cycle wide.
- Channels never interact. Simultaneous presses pulse in the same cycle.
- With REPEAT_EN[i] = 0, HELD is terminal until release.

## Timing
- Reset value: all outputs 0, every FSM in IDLE, synchronizers 0. Reset assertion clears outputs immediately (asynchronous).
- Press latency: `btn_press` rises DB_CYCLES+3 cycles after the `btn_raw` rising edge (2 synchronizer + DB_CYCLES + 1 output register). `btn_level` rises in the same cycle.
- Release latency: `btn_release` pulses DB_CYCLES+3 cycles after the falling edge. `btn_level` falls in the same cycle.
- First repeat: RPT_DELAY_CYCLES after the press pulse. Later repeats: every RPT_PERIOD_CYCLES.
- Any bounce inside a debounce window restarts that window. A pulse train shorter than DB_CYCLES yields no output.
- Reset released with a button held: the press is treated as new. One `btn_press` follows DB_CYCLES+3 cycles after `rst_n` rises; no `btn_release` occurs.
- Counters saturate and never wrap. A held button produces an unbounded repeat stream with no overflow.

## Structure
- Shared package `btn_pkg`: channel state enum (IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE) and a counter-width constant derived via `$clog2` of the largest parameter.
- Sub-module `btn_channel`: synchronizer, FSM, counter and output registers for one button. The top instantiates it 4 times with REPEAT_EN[i].
- Top-level integration: `btn_press` replaces raw `btn` into the time, alarm and date setters. `btn_level` is available for mode logic.

## Test plan
Bench parameters: DB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_PERIOD_CYCLES=8.
- Reset, `btn_raw`=0 for 50 cycles -> all outputs stay 0.
- `btn_raw[0]` rises at cycle 0 and is held 12 cycles:
  - `btn_press[0]` pulses at cycle 7; `btn_level[0]` is 1 for cycles 7–18.
  - `btn_release[0]` pulses at cycle 19.
- `btn_raw[1]` toggles every 2 cycles for 20 cycles, then stays 1 -> exactly one `btn_press[1]`, 7 cycles after the final rising edge.
- `btn_raw[2]` held 60 cycles from cycle 0 -> `btn_press[2]` pulses at 7, 27, 35, 43, 51, 59 and no others.
- Same hold on `btn_raw[3]` with REPEAT_EN=4'b0111 -> only the press at 7 and the release pulse.
- `btn_raw[0]` and `btn_raw[3]` rise together -> both `btn_press` bits pulse in the same cycle.
- Reset mid-REPEAT with `btn_raw[2]` still held:
  - Outputs go to 0 at once.
  - After `rst_n` rises: one `btn_press[2]` 7 cycles later, then repeats resume on the normal schedule.
